// File: rtl/ccd_pkg.sv
// Shared definitions for the CCD acquisition scheduler: trigger-mode
// encodings, FSM state type and the mode sanitiser.
package ccd_pkg;

    localparam logic [15:0] MODE_NORMAL    = 16'd0;
    localparam logic [15:0] MODE_SW        = 16'd1;
    localparam logic [15:0] MODE_EXT_LEVEL = 16'd2;
    localparam logic [15:0] MODE_EXT_SYNC  = 16'd3;
    localparam logic [15:0] MODE_EXT_EDGE  = 16'd4;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_TRIG  = 3'd1,
        ST_LAUNCH     = 3'd2,
        ST_WAIT_FRAME = 3'd3,
        ST_NEXT       = 3'd4
    } state_e;

    // Unknown mode codes fall back to free-run.
    function automatic logic [15:0] norm_mode(input logic [15:0] mode);
        return (mode > MODE_EXT_EDGE) ? MODE_NORMAL : mode;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous pin, plus a rising-edge
// detector on the synchronized level.
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise
);

    logic meta_r;
    logic sync_r;
    logic prev_r;

    // Synchronizer chain plus one history stage for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            prev_r <= 1'b0;
        end else begin
            meta_r <= pin;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign level = sync_r;
    assign rise  = sync_r & ~prev_r;

endmodule

// File: rtl/ccd_acq_scheduler.sv
// Acquisition scheduler: turns the trigger mode into aqui_src launch pulses,
// sequences averaging bursts, and flags trigger overruns and frame timeouts.
module ccd_acq_scheduler
    import ccd_pkg::*;
#(
    parameter int CLK_PER_MS = 48000,
    parameter int LAUNCH_W   = 4,
    parameter int MARGIN_MS  = 100
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        acq_enable,
    input  logic [15:0] trigger_mode,
    input  logic [15:0] int_time_ms,
    input  logic [15:0] scans_to_avg,
    input  logic        sw_trig,
    input  logic        ext_trig,
    input  logic        frame_done,
    input  logic        err_clr,
    output logic        aqui_src,
    output logic        busy,
    output logic [15:0] scan_idx,
    output logic        seq_done,
    output logic        trig_overrun,
    output logic        err_timeout
);

    localparam int                PRE_W    = $clog2(CLK_PER_MS + 1);
    localparam int                LCNT_W   = $clog2(LAUNCH_W + 1);
    localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(CLK_PER_MS - 1);
    localparam logic [LCNT_W-1:0] LCNT_MAX = LCNT_W'(LAUNCH_W);
    localparam logic [16:0]       MARGIN   = 17'(MARGIN_MS);

    state_e             state_r;
    logic [15:0]        mode_r;
    logic [15:0]        len_r;
    logic [16:0]        limit_r;
    logic [PRE_W-1:0]   pre_r;
    logic [16:0]        ms_r;
    logic [LCNT_W-1:0]  lcnt_r;
    logic               aqui_r;
    logic               busy_r;
    logic               seq_done_r;
    logic               overrun_r;
    logic               timeout_r;
    logic [15:0]        scan_idx_r;

    logic               ext_level_s;
    logic               ext_rise_s;
    logic [15:0]        mode_live_s;
    logic [15:0]        len_live_s;
    logic               trig_fire_s;
    logic               tick_s;
    logic               timeout_set_s;
    logic               burst_end_s;
    logic               next_wait_sync_s;
    logic               overrun_set_s;

    sync_edge_det u_ext_sync (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .pin   (ext_trig),
        .level (ext_level_s),
        .rise  (ext_rise_s)
    );

    // Trigger qualification, timeout detection and overrun detection.
    always_comb begin
        mode_live_s = norm_mode(trigger_mode);
        len_live_s  = ((mode_live_s == MODE_EXT_SYNC) || (scans_to_avg == 16'd0))
                      ? 16'd1 : scans_to_avg;
        case (mode_live_s)
            MODE_NORMAL:                  trig_fire_s = 1'b1;
            MODE_SW:                      trig_fire_s = sw_trig;
            MODE_EXT_LEVEL:               trig_fire_s = ext_level_s;
            MODE_EXT_SYNC, MODE_EXT_EDGE: trig_fire_s = ext_rise_s;
            default:                      trig_fire_s = 1'b0;
        endcase
        tick_s           = (state_r == ST_WAIT_FRAME) && (pre_r == PRE_MAX);
        timeout_set_s    = tick_s && !frame_done && ((ms_r + 17'd1) == limit_r);
        burst_end_s      = (scan_idx_r == len_r);
        // A sync-mode rise consumed by the FSM between scans is not an overrun.
        next_wait_sync_s = (state_r == ST_NEXT) && !burst_end_s && (mode_r == MODE_EXT_SYNC);
        overrun_set_s    = busy_r && !next_wait_sync_s &&
                           (((mode_r == MODE_SW) && sw_trig) ||
                            (((mode_r == MODE_EXT_SYNC) || (mode_r == MODE_EXT_EDGE)) && ext_rise_s));
    end

    // Millisecond prescaler and counter, running only while a frame is awaited.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pre_r <= '0;
            ms_r  <= 17'd0;
        end else if (state_r != ST_WAIT_FRAME) begin
            pre_r <= '0;
            ms_r  <= 17'd0;
        end else if (tick_s) begin
            pre_r <= '0;
            ms_r  <= ms_r + 17'd1;
        end else begin
            pre_r <= pre_r + 1'b1;
        end
    end

    // Sticky error flags; a set in the same cycle as err_clr wins.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            overrun_r <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            overrun_r <= overrun_set_s | (overrun_r & ~err_clr);
            timeout_r <= timeout_set_s | (timeout_r & ~err_clr);
        end
    end

    // Acquisition FSM with registered launch, busy, scan index and done outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r    <= ST_IDLE;
            mode_r     <= MODE_NORMAL;
            len_r      <= 16'd1;
            limit_r    <= 17'd0;
            lcnt_r     <= '0;
            aqui_r     <= 1'b0;
            busy_r     <= 1'b0;
            seq_done_r <= 1'b0;
            scan_idx_r <= 16'd0;
        end else begin
            seq_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    aqui_r     <= 1'b0;
                    busy_r     <= 1'b0;
                    scan_idx_r <= 16'd0;
                    state_r    <= acq_enable ? ST_WAIT_TRIG : ST_IDLE;
                end
                ST_WAIT_TRIG: begin
                    if (!acq_enable) begin
                        state_r <= ST_IDLE;
                    end else if (trig_fire_s) begin
                        state_r <= ST_LAUNCH;
                        busy_r  <= 1'b1;
                        lcnt_r  <= '0;
                        mode_r  <= mode_live_s;
                        len_r   <= len_live_s;
                        limit_r <= {1'b0, int_time_ms} + MARGIN;
                    end else begin
                        state_r <= ST_WAIT_TRIG;
                    end
                end
                // The first LAUNCH cycle registers the pulse; it then stays high LAUNCH_W cycles.
                ST_LAUNCH: begin
                    if (lcnt_r == LCNT_MAX) begin
                        aqui_r  <= 1'b0;
                        state_r <= ST_WAIT_FRAME;
                    end else begin
                        aqui_r <= 1'b1;
                        lcnt_r <= lcnt_r + 1'b1;
                    end
                end
                ST_WAIT_FRAME: begin
                    if (frame_done) begin
                        scan_idx_r <= scan_idx_r + 16'd1;
                        seq_done_r <= ((scan_idx_r + 16'd1) == len_r);
                        state_r    <= ST_NEXT;
                    end else if (timeout_set_s) begin
                        scan_idx_r <= 16'd0;
                        busy_r     <= 1'b0;
                        state_r    <= ST_IDLE;
                    end else begin
                        state_r <= ST_WAIT_FRAME;
                    end
                end
                ST_NEXT: begin
                    if (burst_end_s || !acq_enable ||
                        ((mode_r == MODE_EXT_LEVEL) && !ext_level_s)) begin
                        scan_idx_r <= 16'd0;
                    end else begin
                        scan_idx_r <= scan_idx_r;
                    end
                    if (!acq_enable) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else if (burst_end_s) begin
                        if ((mode_r == MODE_NORMAL) ||
                            ((mode_r == MODE_EXT_LEVEL) && ext_level_s)) begin
                            lcnt_r  <= '0;
                            state_r <= ST_LAUNCH;
                        end else begin
                            busy_r  <= 1'b0;
                            state_r <= ST_WAIT_TRIG;
                        end
                    end else if ((mode_r == MODE_EXT_LEVEL) && !ext_level_s) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_WAIT_TRIG;
                    end else if ((mode_r == MODE_EXT_SYNC) && !ext_rise_s) begin
                        state_r <= ST_NEXT;
                    end else begin
                        lcnt_r  <= '0;
                        state_r <= ST_LAUNCH;
                    end
                end
                default: begin
                    aqui_r     <= 1'b0;
                    busy_r     <= 1'b0;
                    scan_idx_r <= 16'd0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    assign aqui_src     = aqui_r;
    assign busy         = busy_r;
    assign scan_idx     = scan_idx_r;
    assign seq_done     = seq_done_r;
    assign trig_overrun = overrun_r;
    assign err_timeout  = timeout_r;

endmodule

// File: tb/tb_ccd_acq_scheduler.sv
// Directed self-checking bench for ccd_acq_scheduler with a shortened
// millisecond (10 cycles) and a 2 ms timeout margin.
module tb_ccd_acq_scheduler;

    localparam int LW = 4;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        acq_enable;
    logic [15:0] trigger_mode;
    logic [15:0] int_time_ms;
    logic [15:0] scans_to_avg;
    logic        sw_trig;
    logic        ext_trig;
    logic        frame_done;
    logic        err_clr;
    logic        aqui_src;
    logic        busy;
    logic [15:0] scan_idx;
    logic        seq_done;
    logic        trig_overrun;
    logic        err_timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int n_launch = 0;
    int n_seq    = 0;
    logic aqui_prev = 1'b0;
    int base_launch;
    int base_seq;

    ccd_acq_scheduler #(
        .CLK_PER_MS (10),
        .LAUNCH_W   (LW),
        .MARGIN_MS  (2)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .acq_enable   (acq_enable),
        .trigger_mode (trigger_mode),
        .int_time_ms  (int_time_ms),
        .scans_to_avg (scans_to_avg),
        .sw_trig      (sw_trig),
        .ext_trig     (ext_trig),
        .frame_done   (frame_done),
        .err_clr      (err_clr),
        .aqui_src     (aqui_src),
        .busy         (busy),
        .scan_idx     (scan_idx),
        .seq_done     (seq_done),
        .trig_overrun (trig_overrun),
        .err_timeout  (err_timeout)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Count launch rising edges and burst-done pulses.
    always @(posedge sys_clk) begin
        if (aqui_src && !aqui_prev) n_launch <= n_launch + 1;
        aqui_prev <= aqui_src;
        if (seq_done) n_seq <= n_seq + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_rise(input string tag);
        int n = 0;
        while (!aqui_src && n < 300) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(aqui_src), 32'd1);
    endtask

    task automatic measure_width(input string tag);
        int w = 0;
        while (aqui_src && w < 20) begin
            tick();
            w++;
        end
        check_eq(tag, 32'(w), 32'(LW));
    endtask

    task automatic pulse_frame();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
    endtask

    initial begin
        sys_rst_n = 1'b0; acq_enable = 1'b0; trigger_mode = 16'd0;
        int_time_ms = 16'd20; scans_to_avg = 16'd3; sw_trig = 1'b0;
        ext_trig = 1'b0; frame_done = 1'b0; err_clr = 1'b0;
        tick(); tick();
        check_eq("rst_aqui", 32'(aqui_src), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_scan_idx", 32'(scan_idx), 32'd0);
        check_eq("rst_seq_done", 32'(seq_done), 32'd0);
        check_eq("rst_overrun", 32'(trig_overrun), 32'd0);
        check_eq("rst_timeout", 32'(err_timeout), 32'd0);
        sys_rst_n = 1'b1;
        tick();

        // Free-run burst of three, frame_done 100 cycles after each launch.
        base_launch = n_launch; base_seq = n_seq;
        acq_enable = 1'b1;
        for (int s = 1; s <= 3; s++) begin
            wait_rise("t1_rise");
            measure_width("t1_width");
            repeat (95) tick();
            pulse_frame();
            check_eq("t1_scan_idx", 32'(scan_idx), 32'(s));
            check_eq("t1_seq_done", 32'(seq_done), (s == 3) ? 32'd1 : 32'd0);
            tick();
        end
        check_eq("t1_idx_cleared", 32'(scan_idx), 32'd0);
        check_eq("t1_busy_relaunch", 32'(busy), 32'd1);
        tick();
        check_eq("t1_relaunch", 32'(aqui_src), 32'd1);
        measure_width("t1_relaunch_width");
        acq_enable = 1'b0;
        pulse_frame();
        tick();
        check_eq("t1_stop_busy", 32'(busy), 32'd0);
        check_eq("t1_stop_idx", 32'(scan_idx), 32'd0);
        check_eq("t1_launches", 32'(n_launch - base_launch), 32'd4);
        check_eq("t1_seq_count", 32'(n_seq - base_seq), 32'd1);

        // Software trigger, scans_to_avg=0, plus an overrun during the frame.
        base_launch = n_launch; base_seq = n_seq;
        trigger_mode = 16'd1; scans_to_avg = 16'd0; acq_enable = 1'b1;
        tick(); tick();
        check_eq("t2_wait_busy", 32'(busy), 32'd0);
        sw_trig = 1'b1; tick(); sw_trig = 1'b0;
        check_eq("t2_lat1", 32'(aqui_src), 32'd0);
        tick();
        check_eq("t2_lat2", 32'(aqui_src), 32'd1);
        measure_width("t2_width");
        repeat (10) tick();
        sw_trig = 1'b1; tick(); sw_trig = 1'b0;
        check_eq("t2_overrun", 32'(trig_overrun), 32'd1);
        repeat (5) tick();
        pulse_frame();
        check_eq("t2_seq_done", 32'(seq_done), 32'd1);
        check_eq("t2_scan_idx", 32'(scan_idx), 32'd1);
        tick();
        check_eq("t2_back_wait", 32'(busy), 32'd0);
        repeat (10) tick();
        check_eq("t2_launches", 32'(n_launch - base_launch), 32'd1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check_eq("t2_overrun_clr", 32'(trig_overrun), 32'd0);

        // External sync: burst forced to one scan, pin-to-launch latency 4.
        base_launch = n_launch; base_seq = n_seq;
        trigger_mode = 16'd3; scans_to_avg = 16'd5;
        tick();
        ext_trig = 1'b1;
        repeat (3) tick();
        check_eq("t3_lat3", 32'(aqui_src), 32'd0);
        tick();
        check_eq("t3_lat4", 32'(aqui_src), 32'd1);
        measure_width("t3_width");
        repeat (5) tick();
        pulse_frame();
        check_eq("t3_seq_done", 32'(seq_done), 32'd1);
        tick();
        check_eq("t3_back_wait", 32'(busy), 32'd0);
        ext_trig = 1'b0;
        repeat (3) tick();
        check_eq("t3_launches", 32'(n_launch - base_launch), 32'd1);

        // External level dropped after two of four scans.
        base_launch = n_launch; base_seq = n_seq;
        trigger_mode = 16'd2; scans_to_avg = 16'd4;
        tick();
        ext_trig = 1'b1;
        wait_rise("t4_rise1");
        measure_width("t4_width1");
        repeat (5) tick();
        pulse_frame();
        check_eq("t4_idx1", 32'(scan_idx), 32'd1);
        wait_rise("t4_rise2");
        measure_width("t4_width2");
        ext_trig = 1'b0;
        repeat (10) tick();
        pulse_frame();
        check_eq("t4_idx2", 32'(scan_idx), 32'd2);
        tick();
        check_eq("t4_idx_abandon", 32'(scan_idx), 32'd0);
        check_eq("t4_busy", 32'(busy), 32'd0);
        check_eq("t4_launches", 32'(n_launch - base_launch), 32'd2);
        check_eq("t4_no_seq", 32'(n_seq - base_seq), 32'd0);

        // Timeout: limit (1+2) ms = 30 cycles in WAIT_FRAME; set-vs-clear race on overrun.
        trigger_mode = 16'd1; int_time_ms = 16'd1;
        sw_trig = 1'b1; tick(); sw_trig = 1'b0;
        wait_rise("t5_rise");
        measure_width("t5_width");
        acq_enable = 1'b0;
        repeat (5) tick();
        sw_trig = 1'b1; err_clr = 1'b1; tick(); sw_trig = 1'b0; err_clr = 1'b0;
        check_eq("t5_set_wins", 32'(trig_overrun), 32'd1);
        repeat (23) tick();
        check_eq("t5_no_timeout_29", 32'(err_timeout), 32'd0);
        check_eq("t5_busy_29", 32'(busy), 32'd1);
        tick();
        check_eq("t5_timeout_30", 32'(err_timeout), 32'd1);
        check_eq("t5_idle", 32'(busy), 32'd0);
        check_eq("t5_idx", 32'(scan_idx), 32'd0);
        pulse_frame();
        check_eq("t5_frame_ignored", 32'(scan_idx), 32'd0);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check_eq("t5_timeout_clr", 32'(err_timeout), 32'd0);
        check_eq("t5_overrun_clr", 32'(trig_overrun), 32'd0);

        // Asynchronous reset in the middle of a launch pulse.
        int_time_ms = 16'd20; acq_enable = 1'b1;
        tick(); tick();
        sw_trig = 1'b1; tick(); sw_trig = 1'b0;
        tick();
        check_eq("t6_pre_aqui", 32'(aqui_src), 32'd1);
        #2 sys_rst_n = 1'b0;
        #1;
        check_eq("t6_async_aqui", 32'(aqui_src), 32'd0);
        check_eq("t6_async_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        tick(); tick();
        check_eq("t6_wait_busy", 32'(busy), 32'd0);
        check_eq("t6_wait_aqui", 32'(aqui_src), 32'd0);
        sw_trig = 1'b1; tick(); sw_trig = 1'b0;
        tick();
        check_eq("t6_relaunch", 32'(aqui_src), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
